ex_issue_stage: RTL and testbench

ID/EX pipeline register and operand issue stage for the pipelined MIPS core; the producer side of the execute-stage ALU interface. It latches decoded control and register-file operands from ID. It drives the ALU operand and control inputs with EX/MEM and MEM/WB forwarding applied. It detects load-use hazards, stalls ID and inserts bubbles. It also honours branch flushes and counts inserted bubbles.

---
 rtl/ex_issue_stage_if.sv | 30 +++
 rtl/ex_issue_stage.sv | 149 ++++++++++++++
 tb/tb_ex_issue_stage.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ex_issue_stage_if.sv
// ALU-side bundle driven by the ID/EX issue stage: registered control plus forwarded operands.
interface ex_issue_stage_if;
    logic        ex_valid;
    logic [31:0] alu_r1;
    logic [31:0] alu_r2;
    logic [31:0] alu_imm;
    logic [4:0]  alu_shamt;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        alu_sl;
    logic        alu_v;
    logic        alu_lui;
    logic        alu_slez;
    logic [4:0]  ex_rd;
    logic        ex_regwrite;
    logic        ex_memread;
    logic [31:0] ex_store_data;

    modport master (
        output ex_valid, alu_r1, alu_r2, alu_imm, alu_shamt, alu_op,
               alu_src, alu_sl, alu_v, alu_lui, alu_slez,
               ex_rd, ex_regwrite, ex_memread, ex_store_data
    );

    modport slave (
        input  ex_valid, alu_r1, alu_r2, alu_imm, alu_shamt, alu_op,
               alu_src, alu_sl, alu_v, alu_lui, alu_slez,
               ex_rd, ex_regwrite, ex_memread, ex_store_data
    );
endinterface

// File: rtl/ex_issue_stage.sv
// ID/EX pipeline register with load-use stall, bubble insertion, flush handling
// and EX/MEM + MEM/WB operand forwarding toward the ALU.
module ex_issue_stage #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [31:0]      id_rs_data,
    input  logic [31:0]      id_rt_data,
    input  logic [31:0]      id_imm,
    input  logic [4:0]       id_shamt,
    input  logic [3:0]       id_aluop,
    input  logic             id_alusrc,
    input  logic             id_sl,
    input  logic             id_v,
    input  logic             id_lui,
    input  logic             id_slez,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    input  logic             exmem_regwrite,
    input  logic [4:0]       exmem_rd,
    input  logic [31:0]      exmem_result,
    input  logic             memwb_regwrite,
    input  logic [4:0]       memwb_rd,
    input  logic [31:0]      memwb_data,
    output logic             stall_id,
    output logic [CNT_W-1:0] bubble_cnt,
    ex_issue_stage_if.master alu_bus
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned OP_W   = 4;

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  shamt;
        logic [OP_W-1:0]   aluop;
        logic              alusrc;
        logic              sl;
        logic              v;
        logic              lui;
        logic              slez;
        logic [REG_W-1:0]  rd;
        logic              regwrite;
        logic              memread;
    } ex_reg_t;

    ex_reg_t           ex_q, ex_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
    logic [DATA_W-1:0] fwd_rs, fwd_rt;
    logic              wb_hit_rs, wb_hit_rt;

    // Load-use hazard against the load currently in EX.
    always_comb begin
        stall_id = ex_q.valid && ex_q.memread && (ex_q.rd != '0) && id_valid &&
                   ((id_use_rs && (id_rs == ex_q.rd)) || (id_use_rt && (id_rt == ex_q.rd)));
    end

    // Next EX contents: ID fields, demoted to a bubble on flush, stall or idle ID.
    always_comb begin
        ex_d         = '0;
        bubble_cnt_d = bubble_cnt_q;
        wb_hit_rs    = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == id_rs);
        wb_hit_rt    = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == id_rt);

        ex_d.rs       = id_rs;
        ex_d.rt       = id_rt;
        ex_d.rs_data  = wb_hit_rs ? memwb_data : id_rs_data;
        ex_d.rt_data  = wb_hit_rt ? memwb_data : id_rt_data;
        ex_d.imm      = id_imm;
        ex_d.shamt    = id_shamt;
        ex_d.aluop    = id_aluop;
        ex_d.alusrc   = id_alusrc;
        ex_d.sl       = id_sl;
        ex_d.v        = id_v;
        ex_d.lui      = id_lui;
        ex_d.slez     = id_slez;
        ex_d.rd       = id_rd;
        ex_d.valid    = id_valid;
        ex_d.regwrite = id_valid && id_regwrite;
        ex_d.memread  = id_valid && id_memread;

        if (flush || stall_id) begin
            ex_d.valid    = 1'b0;
            ex_d.regwrite = 1'b0;
            ex_d.memread  = 1'b0;
            if (bubble_cnt_q != '1) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q         <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ex_q         <= ex_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    // Operand forwarding: EX/MEM beats MEM/WB; register $0 is never forwarded.
    always_comb begin
        fwd_rs = ex_q.rs_data;
        fwd_rt = ex_q.rt_data;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == ex_q.rs)) begin
            fwd_rs = exmem_result;
        end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == ex_q.rs)) begin
            fwd_rs = memwb_data;
        end
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == ex_q.rt)) begin
            fwd_rt = exmem_result;
        end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == ex_q.rt)) begin
            fwd_rt = memwb_data;
        end
    end

    assign bubble_cnt            = bubble_cnt_q;
    assign alu_bus.ex_valid      = ex_q.valid;
    assign alu_bus.alu_r1        = fwd_rs;
    assign alu_bus.alu_r2        = fwd_rt;
    assign alu_bus.ex_store_data = fwd_rt;
    assign alu_bus.alu_imm       = ex_q.imm;
    assign alu_bus.alu_shamt     = ex_q.shamt;
    assign alu_bus.alu_op        = ex_q.aluop;
    assign alu_bus.alu_src       = ex_q.alusrc;
    assign alu_bus.alu_sl        = ex_q.sl;
    assign alu_bus.alu_v         = ex_q.v;
    assign alu_bus.alu_lui       = ex_q.lui;
    assign alu_bus.alu_slez      = ex_q.slez;
    assign alu_bus.ex_rd         = ex_q.rd;
    assign alu_bus.ex_regwrite   = ex_q.regwrite;
    assign alu_bus.ex_memread    = ex_q.memread;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Directed bench for ex_issue_stage: reset, forwarding, load-use stall, capture, flush, saturation.
module tb_ex_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_use_rs, id_use_rt;
    logic [4:0]  id_rs, id_rt, id_shamt, id_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [3:0]  id_aluop;
    logic        id_alusrc, id_sl, id_v, id_lui, id_slez, id_regwrite, id_memread;
    logic        flush;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_data;
    logic        stall_id, stall_id_s;
    logic [15:0] bubble_cnt;
    logic [1:0]  bubble_cnt_s;

    int total = 0;
    int bad   = 0;

    ex_issue_stage_if alu_bus ();
    ex_issue_stage_if alu_bus_s ();

    always #5 clk = ~clk;

    ex_issue_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_imm(id_imm), .id_shamt(id_shamt), .id_aluop(id_aluop),
        .id_alusrc(id_alusrc), .id_sl(id_sl), .id_v(id_v), .id_lui(id_lui), .id_slez(id_slez),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .stall_id(stall_id), .bubble_cnt(bubble_cnt), .alu_bus(alu_bus)
    );

    ex_issue_stage #(.CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_imm(id_imm), .id_shamt(id_shamt), .id_aluop(id_aluop),
        .id_alusrc(id_alusrc), .id_sl(id_sl), .id_v(id_v), .id_lui(id_lui), .id_slez(id_slez),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .stall_id(stall_id_s), .bubble_cnt(bubble_cnt_s), .alu_bus(alu_bus_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_shamt = 0; id_aluop = 0;
        id_alusrc = 0; id_sl = 0; id_v = 0; id_lui = 0; id_slez = 0;
        id_rd = 0; id_regwrite = 0; id_memread = 0; flush = 0;
        exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
        memwb_regwrite = 0; memwb_rd = 0; memwb_data = 0;
    endtask

    task automatic set_lw_r4();
        clear_all();
        id_valid = 1; id_rs = 1; id_use_rs = 1; id_rs_data = 32'h100;
        id_rd = 4; id_regwrite = 1; id_memread = 1;
    endtask

    task automatic set_add_rt4();
        clear_all();
        id_valid = 1; id_rs = 2; id_rt = 4; id_use_rs = 1; id_use_rt = 1;
        id_rs_data = 32'h22; id_rt_data = 32'hDEAD; id_rd = 9; id_regwrite = 1;
    endtask

    initial begin
        // Reset with arbitrary ID contents
        clear_all();
        rst_n = 0;
        id_valid = 1; id_rs = 7; id_rt = 8; id_rs_data = 32'h1234_5678; id_imm = 32'hCAFE;
        id_aluop = 4'h5; id_rd = 3; id_regwrite = 1; id_memread = 1; id_alusrc = 1;
        tick();
        tick();
        chk("rst_ex_valid",   32'(alu_bus.ex_valid), 32'h0);
        chk("rst_alu_imm",    alu_bus.alu_imm,        32'h0);
        chk("rst_alu_op",     32'(alu_bus.alu_op),    32'h0);
        chk("rst_ex_rd",      32'(alu_bus.ex_rd),     32'h0);
        chk("rst_memread",    32'(alu_bus.ex_memread), 32'h0);
        chk("rst_alu_r1",     alu_bus.alu_r1,         32'h0);
        chk("rst_bubble_cnt", 32'(bubble_cnt),        32'h0);

        // Plain load, then EX/MEM forwarding and dual-match priority
        rst_n = 1;
        clear_all();
        id_valid = 1; id_rs = 3; id_rt = 5; id_use_rs = 1; id_use_rt = 1;
        id_rs_data = 32'h7; id_rt_data = 32'h9; id_imm = 32'h1234; id_shamt = 5'd3;
        id_aluop = 4'hA; id_alusrc = 1; id_sl = 1; id_rd = 8; id_regwrite = 1;
        tick();
        chk("load_ex_valid",  32'(alu_bus.ex_valid),   32'h1);
        chk("load_alu_imm",   alu_bus.alu_imm,         32'h1234);
        chk("load_alu_op",    32'(alu_bus.alu_op),     32'hA);
        chk("load_shamt",     32'(alu_bus.alu_shamt),  32'h3);
        chk("load_alu_src",   32'(alu_bus.alu_src),    32'h1);
        chk("load_alu_sl",    32'(alu_bus.alu_sl),     32'h1);
        chk("load_ex_rd",     32'(alu_bus.ex_rd),      32'h8);
        chk("load_regwrite",  32'(alu_bus.ex_regwrite), 32'h1);
        chk("load_alu_r1",    alu_bus.alu_r1,          32'h7);
        exmem_regwrite = 1; exmem_rd = 3; exmem_result = 32'h10;
        #1;
        chk("exmem_fwd_r1",   alu_bus.alu_r1,          32'h10);
        exmem_rd = 5; exmem_result = 32'h1;
        memwb_regwrite = 1; memwb_rd = 5; memwb_data = 32'h2;
        #1;
        chk("dual_r2",        alu_bus.alu_r2,          32'h1);
        chk("dual_store",     alu_bus.ex_store_data,   32'h1);
        chk("dual_r1_nofwd",  alu_bus.alu_r1,          32'h7);
        exmem_regwrite = 0;
        #1;
        chk("memwb_only_r2",  alu_bus.alu_r2,          32'h2);

        // Load-use hazard: lw r4 then add using r4
        set_lw_r4();
        tick();
        chk("lw_memread",     32'(alu_bus.ex_memread), 32'h1);
        set_add_rt4();
        #1;
        chk("lu_stall",       32'(stall_id),           32'h1);
        tick();
        chk("lu_bubble_valid", 32'(alu_bus.ex_valid),  32'h0);
        chk("lu_bubble_rw",   32'(alu_bus.ex_regwrite), 32'h0);
        chk("lu_cnt",         32'(bubble_cnt),         32'h1);
        chk("lu_stall_clear", 32'(stall_id),           32'h0);
        tick();
        memwb_regwrite = 1; memwb_rd = 4; memwb_data = 32'hABCD;
        #1;
        chk("lu_add_valid",   32'(alu_bus.ex_valid),   32'h1);
        chk("lu_add_r2",      alu_bus.alu_r2,          32'hABCD);
        chk("lu_add_r1",      alu_bus.alu_r1,          32'h22);
        chk("lu_cnt_hold",    32'(bubble_cnt),         32'h1);

        // Register $0 is neither captured nor forwarded
        clear_all();
        id_valid = 1; id_rs = 0; id_use_rs = 1; id_rs_data = 32'h0;
        memwb_regwrite = 1; memwb_rd = 0; memwb_data = 32'h99;
        tick();
        exmem_regwrite = 1; exmem_rd = 0; exmem_result = 32'hFFFF;
        memwb_regwrite = 1; memwb_rd = 0; memwb_data = 32'h77;
        #1;
        chk("zero_no_fwd",    alu_bus.alu_r1,          32'h0);

        // WB-same-cycle capture into the EX register
        clear_all();
        id_valid = 1; id_rs = 6; id_use_rs = 1; id_rs_data = 32'h11;
        memwb_regwrite = 1; memwb_rd = 6; memwb_data = 32'h55;
        tick();
        memwb_regwrite = 0; memwb_rd = 0; memwb_data = 0;
        #1;
        chk("capture_r1",     alu_bus.alu_r1,          32'h55);

        // Flush together with a hazard: single bubble, counted once
        set_lw_r4();
        tick();
        set_add_rt4();
        flush = 1;
        #1;
        chk("fl_stall_seen",  32'(stall_id),           32'h1);
        tick();
        chk("fl_valid",       32'(alu_bus.ex_valid),   32'h0);
        chk("fl_cnt",         32'(bubble_cnt),         32'h2);
        flush = 0;
        #1;
        chk("fl_no_stall",    32'(stall_id),           32'h0);
        tick();
        chk("fl_next_valid",  32'(alu_bus.ex_valid),   32'h1);
        chk("fl_next_cnt",    32'(bubble_cnt),         32'h2);

        // Idle ID: bubble, not counted; flush with idle ID: counted
        clear_all();
        tick();
        chk("idle_valid",     32'(alu_bus.ex_valid),   32'h0);
        chk("idle_cnt",       32'(bubble_cnt),         32'h2);
        flush = 1;
        tick();
        chk("fl_idle_cnt",    32'(bubble_cnt),         32'h3);
        chk("sat_cnt_pre",    32'(bubble_cnt_s),       32'h3);

        // Saturation of the narrow counter over five more flushes
        for (int i = 0; i < 5; i++) begin
            id_valid = 1; id_rd = 5'(i + 1); id_regwrite = 1;
            tick();
        end
        chk("wide_cnt",       32'(bubble_cnt),         32'h8);
        chk("sat_cnt",        32'(bubble_cnt_s),       32'h3);
        chk("sat_ex_valid",   32'(alu_bus_s.ex_valid), 32'h0);

        // Reset in the middle of a stall clears everything
        set_lw_r4();
        tick();
        set_add_rt4();
        #1;
        chk("rs_stall_seen",  32'(stall_id),           32'h1);
        rst_n = 0;
        tick();
        chk("rs_cnt",         32'(bubble_cnt),         32'h0);
        chk("rs_cnt_s",       32'(bubble_cnt_s),       32'h0);
        chk("rs_valid",       32'(alu_bus.ex_valid),   32'h0);
        chk("rs_memread",     32'(alu_bus.ex_memread), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
